// File: rtl/uart_cmd_framer.sv
// Turns the UART receiver's ready-flagged byte stream into checksum-validated
// command packets, with inter-byte timeout and coded error pulses.
module uart_cmd_framer #(
  parameter int MAX_LEN     = 4,
  parameter int TIMEOUT_CYC = 52080
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_rdy,
  input  logic [7:0]           i_rx_data,
  output logic                 o_clr_rdy,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ack,
  output logic [7:0]           o_cmd_opcode,
  output logic [2:0]           o_cmd_len,
  output logic [8*MAX_LEN-1:0] o_cmd_payload,
  output logic                 o_frame_err,
  output logic [1:0]           o_err_code
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  // The error is registered, so it fires one count early to land exactly
  // TIMEOUT_CYC cycles after the last byte; the timer never exceeds this value.
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 2);

  localparam logic [7:0] HEADER      = 8'hA5;
  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_HUNT,
    S_OPC,
    S_LEN,
    S_PAY,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t               r_state;
  logic [TMR_W-1:0]     r_timer;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_xor;
  logic                 r_cmdValid;
  logic [7:0]           r_cmdOpcode;
  logic [2:0]           r_cmdLen;
  logic [8*MAX_LEN-1:0] r_cmdPayload;
  logic                 r_frameErr;
  logic [1:0]           r_errCode;

  logic w_lenBad;
  logic w_lastPay;
  logic w_timeout;

  assign o_clr_rdy     = i_rx_rdy & ~rst;
  assign o_cmd_valid   = r_cmdValid;
  assign o_cmd_opcode  = r_cmdOpcode;
  assign o_cmd_len     = r_cmdLen;
  assign o_cmd_payload = r_cmdPayload;
  assign o_frame_err   = r_frameErr;
  assign o_err_code    = r_errCode;

  assign w_lenBad  = (i_rx_data > 8'(MAX_LEN));
  assign w_lastPay = ((3'(r_idx) + 3'd1) == r_cmdLen);
  assign w_timeout = (r_timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_HUNT;
      r_timer      <= '0;
      r_idx        <= '0;
      r_xor        <= '0;
      r_cmdValid   <= 1'b0;
      r_cmdOpcode  <= '0;
      r_cmdLen     <= '0;
      r_cmdPayload <= '0;
      r_frameErr   <= 1'b0;
      r_errCode    <= '0;
    end else begin
      r_frameErr <= 1'b0;
      case (r_state)
        S_HUNT: begin
          r_timer <= '0;
          if (i_rx_rdy && (i_rx_data == HEADER)) begin
            r_cmdPayload <= '0;
            r_xor        <= '0;
            r_state      <= S_OPC;
          end
        end

        S_HOLD: begin
          r_timer <= '0;
          if (i_rx_rdy) begin
            r_frameErr <= 1'b1;
            r_errCode  <= ERR_OVERRUN;
          end
          if (i_cmd_ack) begin
            r_cmdValid <= 1'b0;
            r_state    <= S_HUNT;
          end
        end

        default: begin
          // In-frame states: a byte arriving on the timeout cycle wins.
          if (i_rx_rdy) begin
            r_timer <= '0;
            case (r_state)
              S_OPC: begin
                r_cmdOpcode <= i_rx_data;
                r_xor       <= r_xor ^ i_rx_data;
                r_state     <= S_LEN;
              end

              S_LEN: begin
                if (w_lenBad) begin
                  r_frameErr <= 1'b1;
                  r_errCode  <= ERR_LEN;
                  r_state    <= S_HUNT;
                end else begin
                  r_cmdLen <= i_rx_data[2:0];
                  r_xor    <= r_xor ^ i_rx_data;
                  r_idx    <= '0;
                  r_state  <= (i_rx_data == 8'd0) ? S_CSUM : S_PAY;
                end
              end

              S_PAY: begin
                for (int i = 0; i < MAX_LEN; i++) begin
                  if (r_idx == IDX_W'(i)) begin
                    r_cmdPayload[8*i +: 8] <= i_rx_data;
                  end
                end
                r_xor <= r_xor ^ i_rx_data;
                if (w_lastPay) begin
                  r_state <= S_CSUM;
                end else begin
                  r_idx <= r_idx + IDX_W'(1);
                end
              end

              S_CSUM: begin
                if (i_rx_data == r_xor) begin
                  r_cmdValid <= 1'b1;
                  r_state    <= S_HOLD;
                end else begin
                  r_frameErr <= 1'b1;
                  r_errCode  <= ERR_CSUM;
                  r_state    <= S_HUNT;
                end
              end

              default: r_state <= S_HUNT;
            endcase
          end else if (w_timeout) begin
            r_timer    <= '0;
            r_frameErr <= 1'b1;
            r_errCode  <= ERR_TIMEOUT;
            r_state    <= S_HUNT;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Directed bench for uart_cmd_framer: frames, error codes, timeout boundary,
// overrun in HOLD and mid-frame reset, checked with immediate assertions.
module tb_uart_cmd_framer;

  localparam int MAX_LEN     = 4;
  localparam int TIMEOUT_CYC = 100;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 rxRdy = 1'b0;
  logic [7:0]           rxData = 8'h00;
  logic                 cmdAck = 1'b0;
  logic                 clrRdy;
  logic                 cmdValid;
  logic [7:0]           cmdOpcode;
  logic [2:0]           cmdLen;
  logic [8*MAX_LEN-1:0] cmdPayload;
  logic                 frameErr;
  logic [1:0]           errCode;

  int checks = 0;
  int errors = 0;
  int clrPulses = 0;
  int clrBase = 0;

  uart_cmd_framer #(
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx_rdy     (rxRdy),
    .i_rx_data    (rxData),
    .o_clr_rdy    (clrRdy),
    .o_cmd_valid  (cmdValid),
    .i_cmd_ack    (cmdAck),
    .o_cmd_opcode (cmdOpcode),
    .o_cmd_len    (cmdLen),
    .o_cmd_payload(cmdPayload),
    .o_frame_err  (frameErr),
    .o_err_code   (errCode)
  );

  always #5 clk = ~clk;

  // Tally of cycles in which the receiver was told to drop its ready flag.
  always @(posedge clk) begin
    if (clrRdy) clrPulses <= clrPulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one byte for one cycle starting at a falling edge; returns at
  // the next falling edge, where registered results of that byte are visible.
  task automatic applyStimulus(input logic [7:0] b);
    rxRdy  = 1'b1;
    rxData = b;
    #1;
    checkOutput("clr_rdy", 32'(clrRdy), 32'd1);
    @(negedge clk);
    rxRdy  = 1'b0;
    rxData = 8'h00;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ackCmd();
    cmdAck = 1'b1;
    @(negedge clk);
    cmdAck = 1'b0;
  endtask

  task automatic checkCmd(input string tag, input logic [7:0] opc,
                          input logic [2:0] len, input logic [31:0] pay);
    checkOutput({tag, "_valid"}, 32'(cmdValid), 32'd1);
    checkOutput({tag, "_opcode"}, 32'(cmdOpcode), 32'(opc));
    checkOutput({tag, "_len"}, 32'(cmdLen), 32'(len));
    checkOutput({tag, "_payload"}, cmdPayload, pay);
    checkOutput({tag, "_frame_err"}, 32'(frameErr), 32'd0);
  endtask

  task automatic checkErr(input string tag, input logic [1:0] code);
    checkOutput({tag, "_frame_err"}, 32'(frameErr), 32'd1);
    checkOutput({tag, "_err_code"}, 32'(errCode), 32'(code));
    checkOutput({tag, "_valid"}, 32'(cmdValid), 32'd0);
  endtask

  initial begin
    // Reset with a byte pending: clr_rdy must stay low and outputs clear.
    #1;
    rst    = 1'b1;
    rxRdy  = 1'b1;
    rxData = 8'hA5;
    #1;
    checkOutput("rst_clr_rdy", 32'(clrRdy), 32'd0);
    checkOutput("rst_valid", 32'(cmdValid), 32'd0);
    checkOutput("rst_frame_err", 32'(frameErr), 32'd0);
    checkOutput("rst_err_code", 32'(errCode), 32'd0);
    checkOutput("rst_opcode", 32'(cmdOpcode), 32'd0);
    checkOutput("rst_payload", cmdPayload, 32'd0);
    @(negedge clk);
    rxRdy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Good frame; checksum 10^02^34^56 = 70.
    clrBase = clrPulses;
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    checkOutput("good_valid_early", 32'(cmdValid), 32'd0);
    applyStimulus(8'h70);
    checkCmd("good", 8'h10, 3'd2, 32'h0000_5634);
    checkOutput("good_clr_pulses", 32'(clrPulses - clrBase), 32'd6);
    idleCycles(3);
    checkOutput("good_hold_valid", 32'(cmdValid), 32'd1);
    checkOutput("good_hold_payload", cmdPayload, 32'h0000_5634);
    ackCmd();
    checkOutput("good_after_ack", 32'(cmdValid), 32'd0);

    // Bad checksum, then a good frame is accepted again.
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h71);
    checkErr("csum", 2'b10);
    idleCycles(1);
    checkOutput("csum_pulse_end", 32'(frameErr), 32'd0);
    checkOutput("csum_code_hold", 32'(errCode), 32'd2);
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h70);
    checkCmd("recover", 8'h10, 3'd2, 32'h0000_5634);
    ackCmd();
    checkOutput("recover_after_ack", 32'(cmdValid), 32'd0);

    // Ack while idle is ignored; junk dropped silently; zero-length frame.
    ackCmd();
    checkOutput("idle_ack_valid", 32'(cmdValid), 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    checkOutput("junk_no_err", 32'(frameErr), 32'd0);
    applyStimulus(8'hA5);
    applyStimulus(8'h07);
    applyStimulus(8'h00);
    applyStimulus(8'h07);
    checkCmd("zlen", 8'h07, 3'd0, 32'h0000_0000);
    ackCmd();

    // Length 5 exceeds MAX_LEN; the next byte is a fresh header in HUNT.
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h05);
    checkErr("badlen", 2'b01);
    applyStimulus(8'hA5);
    checkOutput("badlen_pulse_end", 32'(frameErr), 32'd0);
    applyStimulus(8'h09);
    applyStimulus(8'h01);
    applyStimulus(8'h33);
    applyStimulus(8'h3B);
    checkCmd("after_badlen", 8'h09, 3'd1, 32'h0000_0033);

    // Byte while holding: overrun, command untouched.
    applyStimulus(8'h33);
    checkOutput("ovr_frame_err", 32'(frameErr), 32'd1);
    checkOutput("ovr_err_code", 32'(errCode), 32'd0);
    checkOutput("ovr_valid", 32'(cmdValid), 32'd1);
    checkOutput("ovr_opcode", 32'(cmdOpcode), 32'h09);
    checkOutput("ovr_payload", cmdPayload, 32'h0000_0033);
    ackCmd();
    checkOutput("ovr_after_ack", 32'(cmdValid), 32'd0);

    // Timeout: error exactly TIMEOUT_CYC cycles after the 0x20 byte.
    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    idleCycles(TIMEOUT_CYC - 2);
    checkOutput("tmo_not_yet", 32'(frameErr), 32'd0);
    idleCycles(1);
    checkErr("tmo", 2'b11);
    idleCycles(1);
    checkOutput("tmo_pulse_end", 32'(frameErr), 32'd0);

    // A byte on the last allowed cycle cancels the timeout; 20^02^11^22 = 11.
    applyStimulus(8'hA5);
    applyStimulus(8'h20);
    idleCycles(TIMEOUT_CYC - 2);
    applyStimulus(8'h02);
    checkOutput("tmo_cancel", 32'(frameErr), 32'd0);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h11);
    checkCmd("tmo_frame", 8'h20, 3'd2, 32'h0000_2211);

    // Ack and a byte in the same cycle: released, and still an overrun.
    cmdAck = 1'b1;
    applyStimulus(8'hA5);
    cmdAck = 1'b0;
    checkOutput("ackovr_valid", 32'(cmdValid), 32'd0);
    checkOutput("ackovr_frame_err", 32'(frameErr), 32'd1);
    checkOutput("ackovr_err_code", 32'(errCode), 32'd0);

    // Leave a nonzero error code and opcode, then reset mid-frame.
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h06);
    checkErr("badlen2", 2'b01);
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    rst = 1'b1;
    #1;
    checkOutput("midrst_opcode", 32'(cmdOpcode), 32'd0);
    checkOutput("midrst_err_code", 32'(errCode), 32'd0);
    checkOutput("midrst_frame_err", 32'(frameErr), 32'd0);
    checkOutput("midrst_valid", 32'(cmdValid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    applyStimulus(8'h70);
    checkCmd("post_rst", 8'h10, 3'd2, 32'h0000_5634);
    ackCmd();
    checkOutput("post_rst_ack", 32'(cmdValid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
